// File: rtl/core_pkg.sv
// Shared core definitions: ALU control codes, RV32M funct3 encoding and
// the multiply/divide sequencer state encoding.
package core_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: shift-add multiply and restoring divide,
// one iteration per granted cycle on the shared core ALU.
module muldiv_sequencer
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  seq_state_e      state;
  muldiv_op_e      op_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  // hi/lo hold {product high, multiplier/product low} or {remainder, quotient}
  logic [XLEN-1:0] hi, lo, bop;
  logic [CW-1:0]   cnt;
  logic            neg_res, neg_rem;

  logic            is_div, s1_signed, s2_signed, neg1, neg2, ovf;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [XLEN-1:0] rem_s, fix_result;
  logic            carry, ge;
  logic [2*XLEN-1:0] prod_s;

  function automatic logic [XLEN-1:0] op_a(input logic d, input logic [XLEN-1:0] h,
                                           input logic [XLEN-1:0] l);
    return d ? {h[XLEN-2:0], l[XLEN-1]} : h;
  endfunction

  function automatic logic [XLEN-1:0] op_b(input logic d, input logic [XLEN-1:0] l,
                                           input logic [XLEN-1:0] b);
    return (d || l[0]) ? b : '0;
  endfunction

  assign is_div    = op_q[2];
  assign s1_signed = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                     (is_div && !op_q[0]);
  assign s2_signed = (op_q == OP_MUL) || (op_q == OP_MULH) || (is_div && !op_q[0]);
  assign neg1      = s1_signed && rs1_q[XLEN-1];
  assign neg2      = s2_signed && rs2_q[XLEN-1];
  assign mag1      = neg1 ? ('0 - rs1_q) : rs1_q;
  assign mag2      = neg2 ? ('0 - rs2_q) : rs2_q;
  assign ovf       = is_div && !op_q[0] && (rs1_q == MIN_NEG) && (rs2_q == '1);

  always_comb begin
    carry   = 1'b0;
    ge      = 1'b0;
    rem_s   = {hi[XLEN-2:0], lo[XLEN-1]};
    step_hi = hi;
    step_lo = lo;
    if (is_div) begin
      // hi[XLEN-1] is the bit shifted out of the partial remainder
      ge      = hi[XLEN-1] || (rem_s >= bop);
      step_hi = ge ? alu_result : rem_s;
      step_lo = {lo[XLEN-2:0], ge};
    end else begin
      carry   = alu_result < hi;
      step_hi = {carry, alu_result[XLEN-1:1]};
      step_lo = {alu_result[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_s     = neg_res ? ('0 - {hi, lo}) : {hi, lo};
    fix_result = '0;
    case (op_q)
      OP_MUL:                       fix_result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_result = neg_res ? ('0 - lo) : lo;
      OP_REM, OP_REMU:              fix_result = neg_rem ? ('0 - hi) : hi;
      default:                      fix_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= OP_MUL;
      rs1_q       <= '0;
      rs2_q       <= '0;
      hi          <= '0;
      lo          <= '0;
      bop         <= '0;
      cnt         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      alu_req     <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= ALU_ADD;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= muldiv_op_e'(op);
            rs1_q <= rs1;
            rs2_q <= rs2;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          neg_res <= neg1 ^ neg2;
          neg_rem <= neg1;
          if (is_div && (rs2_q == '0)) begin
            result <= op_q[1] ? rs1_q : '1;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else if (ovf) begin
            result <= op_q[1] ? '0 : MIN_NEG;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            hi          <= '0;
            lo          <= mag1;
            bop         <= mag2;
            cnt         <= '0;
            alu_req     <= 1'b1;
            alu_control <= is_div ? ALU_SUB : ALU_ADD;
            alu_a       <= op_a(is_div, '0, mag1);
            alu_b       <= op_b(is_div, mag1, mag2);
            state       <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (alu_gnt) begin
            hi  <= step_hi;
            lo  <= step_lo;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              alu_req     <= 1'b0;
              alu_a       <= '0;
              alu_b       <= '0;
              alu_control <= ALU_ADD;
              state       <= ST_FIX;
            end else begin
              // operands are registered, so prepare the next iteration's inputs now
              alu_a <= op_a(is_div, step_hi, step_lo);
              alu_b <= op_b(is_div, step_lo, bop);
            end
          end
        end
        ST_FIX: begin
          result <= fix_result;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
